hfrv_mem_arbiter: RTL and testbench

//  Shares the single-port program/data RAM of the HF-RISC verification top between the bench

---
 rtl/hfrv_mem_pkg.sv | 7 +
 rtl/hfrv_rr_arb2.sv | 27 ++
 rtl/hfrv_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_hfrv_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hfrv_mem_pkg.sv
// Shared types for the HF-RISC verification-top memory arbiter.
package hfrv_mem_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {LOAD, RELEASE, RUN} arb_state_e;
  typedef enum logic {OWN_LD, OWN_CPU} owner_e;
endpackage

// File: rtl/hfrv_rr_arb2.sv
// Two-way round-robin between loader and core; a lone requester wins outright,
// and on a tie the side not granted last goes first.
module hfrv_rr_arb2
  import hfrv_mem_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic ld_req_i,
  input  logic cpu_req_i,
  output logic ld_gnt_o,
  output logic cpu_gnt_o
);
  owner_e rr_last_q, rr_last_d;

  always_comb begin
    ld_gnt_o  = ld_req_i  & (~cpu_req_i | (rr_last_q == OWN_CPU));
    cpu_gnt_o = cpu_req_i & (~ld_req_i  | (rr_last_q == OWN_LD));
    rr_last_d = rr_last_q;
    if (ld_gnt_o)       rr_last_d = OWN_LD;
    else if (cpu_gnt_o) rr_last_d = OWN_CPU;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_last_q <= OWN_CPU;
    else         rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/hfrv_mem_arbiter.sv
// Shares the single-port RAM between the program loader and the core: holds the core
// in reset during load, then round-robins loader backdoor accesses against core traffic.
module hfrv_mem_arbiter
  import hfrv_mem_pkg::*;
#(
  parameter int MEM_AW      = 16,
  parameter int RELEASE_CYC = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [31:0]       ld_addr_i,
  input  logic [31:0]       ld_wdata_i,
  input  logic              ld_done_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  input  logic              cpu_req_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [3:0]        cpu_wbe_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic              cpu_stall_o,
  output logic              cpu_reset_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_wbe_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              oor_err_o,
  output logic [15:0]       ld_words_o
);
  arb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cpu_en;
  logic        ld_req_eff, cpu_req_eff;
  logic        any_gnt, acc_rd, acc_oor;
  logic [31:0] acc_addr;
  logic        rd_vld_q, rd_vld_d, rd_oor_q, rd_oor_d;
  owner_e      rd_own_q, rd_own_d;
  logic        oor_err_q, oor_err_d;
  logic [15:0] ld_words_q, ld_words_d;
  logic        unused_addr_lsbs;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: if (ld_done_i) begin
        state_d = RELEASE;
        cnt_d   = 4'(RELEASE_CYC);
      end
      RELEASE: begin
        if (cnt_q == 4'd1) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    cpu_en      = (state_q == RUN);
    cpu_reset_o = reset_i | (state_q != RUN);
  end

  // Nothing is granted while reset is asserted, whatever state the FSM is leaving.
  assign ld_req_eff  = ld_req_i & ~reset_i;
  assign cpu_req_eff = cpu_req_i & cpu_en & ~reset_i;

  hfrv_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ld_req_i  (ld_req_eff),
    .cpu_req_i (cpu_req_eff),
    .ld_gnt_o  (ld_gnt_o),
    .cpu_gnt_o (cpu_gnt_o)
  );

  assign cpu_stall_o = cpu_req_eff & ~cpu_gnt_o;

  always_comb begin
    any_gnt     = ld_gnt_o | cpu_gnt_o;
    acc_addr    = cpu_gnt_o ? cpu_addr_i : ld_addr_i;
    acc_rd      = cpu_gnt_o ? (cpu_wbe_i == 4'h0) : ~ld_we_i;
    acc_oor     = |acc_addr[31:MEM_AW+2];
    mem_en_o    = any_gnt & ~acc_oor;
    mem_addr_o  = acc_addr[MEM_AW+1:2];
    mem_wdata_o = cpu_gnt_o ? cpu_wdata_i : ld_wdata_i;
    mem_wbe_o   = 4'h0;
    if (mem_en_o) mem_wbe_o = cpu_gnt_o ? cpu_wbe_i : {4{ld_we_i}};
  end

  assign unused_addr_lsbs = ^acc_addr[1:0];

  always_comb begin
    rd_vld_d   = any_gnt & acc_rd;
    rd_own_d   = cpu_gnt_o ? OWN_CPU : OWN_LD;
    rd_oor_d   = acc_oor;
    oor_err_d  = oor_err_q | (any_gnt & acc_oor);
    ld_words_d = ld_words_q;
    if (ld_gnt_o && ld_we_i && ld_words_q != 16'hFFFF) ld_words_d = ld_words_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_vld_q   <= 1'b0;
      rd_own_q   <= OWN_LD;
      rd_oor_q   <= 1'b0;
      oor_err_q  <= 1'b0;
      ld_words_q <= '0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      rd_own_q   <= rd_own_d;
      rd_oor_q   <= rd_oor_d;
      oor_err_q  <= oor_err_d;
      ld_words_q <= ld_words_d;
    end
  end

  // An out-of-range read never touched the RAM, so its stale output is masked.
  assign ld_rvalid_o  = rd_vld_q & (rd_own_q == OWN_LD)  & ~reset_i;
  assign cpu_rvalid_o = rd_vld_q & (rd_own_q == OWN_CPU) & ~reset_i;
  assign rdata_o      = rd_oor_q ? '0 : mem_rdata_i;
  assign oor_err_o    = oor_err_q;
  assign ld_words_o   = ld_words_q;
endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Directed bench for hfrv_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_hfrv_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, ld_we, ld_done;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic        cpu_req;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wbe;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, cpu_reset;
  logic [31:0] rdata;
  logic        mem_en;
  logic [3:0]  mem_wbe;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        oor_err;
  logic [15:0] ld_words;

  logic [31:0] ram [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hfrv_mem_arbiter #(.MEM_AW(16), .RELEASE_CYC(4)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .ld_req_i     (ld_req),
    .ld_we_i      (ld_we),
    .ld_addr_i    (ld_addr),
    .ld_wdata_i   (ld_wdata),
    .ld_done_i    (ld_done),
    .ld_gnt_o     (ld_gnt),
    .ld_rvalid_o  (ld_rvalid),
    .cpu_req_i    (cpu_req),
    .cpu_addr_i   (cpu_addr),
    .cpu_wbe_i    (cpu_wbe),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_gnt_o    (cpu_gnt),
    .cpu_rvalid_o (cpu_rvalid),
    .cpu_stall_o  (cpu_stall),
    .cpu_reset_o  (cpu_reset),
    .rdata_o      (rdata),
    .mem_en_o     (mem_en),
    .mem_wbe_o    (mem_wbe),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .oor_err_o    (oor_err),
    .ld_words_o   (ld_words)
  );

  // Read-first RAM model with byte enables.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wbe[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ld_req = 1'b0; ld_we = 1'b0; ld_done = 1'b0;
    ld_addr = '0; ld_wdata = '0;
    cpu_req = 1'b1; cpu_addr = '0; cpu_wbe = '0; cpu_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("rst_ld_words",  32'(ld_words),  32'd0);
    check_eq("rst_oor_err",   32'(oor_err),   32'd0);
    check_eq("rst_cpu_gnt",   32'(cpu_gnt),   32'd0);
    check_eq("rst_cpu_rvalid",32'(cpu_rvalid),32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("load_cpu_gnt",   32'(cpu_gnt),   32'd0);
    check_eq("load_cpu_stall", 32'(cpu_stall), 32'd0);

    // program load with core requesting throughout
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'(i * 4);
      ld_wdata = (i == 2) ? 32'hDEAD0013 : 32'h00000013;
      #1;
      check_eq("load_ld_gnt",  32'(ld_gnt),   32'd1);
      check_eq("load_cpu_gnt", 32'(cpu_gnt),  32'd0);
      check_eq("load_mem_wbe", 32'(mem_wbe),  32'hF);
      check_eq("load_mem_addr",32'(mem_addr), 32'(i));
    end
    @(negedge clk);
    ld_req = 1'b0; ld_we = 1'b0; ld_done = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ld_done = 1'b0;
      if (k == 4) cpu_req = 1'b0;
      #1;
      check_eq("release_cpu_reset", 32'(cpu_reset), (k <= 4) ? 32'd1 : 32'd0);
      if (k == 2) begin
        check_eq("release_cpu_gnt", 32'(cpu_gnt),  32'd0);
        check_eq("load_ld_words",   32'(ld_words), 32'd4);
      end
    end

    // core read, single requester
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h8; cpu_wbe = 4'h0;
    #1;
    check_eq("rd_cpu_gnt",  32'(cpu_gnt),  32'd1);
    check_eq("rd_mem_en",   32'(mem_en),   32'd1);
    check_eq("rd_mem_addr", 32'(mem_addr), 32'd2);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    check_eq("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("rd_ld_rvalid",  32'(ld_rvalid),  32'd0);
    check_eq("rd_rdata",      rdata,           32'hDEAD0013);

    // loader read alone, leaves loader as last granted
    @(negedge clk);
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0;
    #1;
    check_eq("ldrd_gnt", 32'(ld_gnt), 32'd1);
    @(negedge clk);
    ld_req = 1'b0;
    #1;
    check_eq("ldrd_rvalid", 32'(ld_rvalid), 32'd1);
    check_eq("ldrd_rdata",  rdata,          32'h00000013);

    // contention: both request for four cycles
    ld_addr = 32'h4; cpu_addr = 32'hC;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      ld_req = (c < 4); cpu_req = (c < 4);
      #1;
      if (c < 4) begin
        check_eq("rr_cpu_gnt",   32'(cpu_gnt),   (c % 2 == 0) ? 32'd1 : 32'd0);
        check_eq("rr_ld_gnt",    32'(ld_gnt),    (c % 2 == 1) ? 32'd1 : 32'd0);
        check_eq("rr_cpu_stall", 32'(cpu_stall), (c % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (c > 0) begin
        check_eq("rr_cpu_rvalid", 32'(cpu_rvalid), ((c - 1) % 2 == 0) ? 32'd1 : 32'd0);
        check_eq("rr_ld_rvalid",  32'(ld_rvalid),  ((c - 1) % 2 == 1) ? 32'd1 : 32'd0);
        check_eq("rr_rdata",      rdata,           32'h00000013);
      end
    end

    // core byte write then readback
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h4; cpu_wbe = 4'b0010; cpu_wdata = 32'hAABBCCDD;
    #1;
    check_eq("wr_cpu_gnt",   32'(cpu_gnt), 32'd1);
    check_eq("wr_mem_wbe",   32'(mem_wbe), 32'h2);
    check_eq("wr_mem_wdata", mem_wdata,    32'hAABBCCDD);
    @(negedge clk);
    cpu_wbe = 4'h0;
    #1;
    check_eq("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
    check_eq("rb_cpu_gnt",   32'(cpu_gnt),    32'd1);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    check_eq("rb_cpu_rvalid", 32'(cpu_rvalid),  32'd1);
    check_eq("rb_byte1",      32'(rdata[15:8]), 32'hCC);
    check_eq("rb_rdata",      rdata,            32'h0000CC13);

    // out-of-range loader read
    @(negedge clk);
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0004_0000;
    #1;
    check_eq("oor_ld_gnt", 32'(ld_gnt), 32'd1);
    check_eq("oor_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    ld_req = 1'b0;
    #1;
    check_eq("oor_ld_rvalid", 32'(ld_rvalid), 32'd1);
    check_eq("oor_rdata",     rdata,          32'h0);
    check_eq("oor_err_set",   32'(oor_err),   32'd1);
    repeat (2) @(negedge clk);
    #1;
    check_eq("oor_err_sticky", 32'(oor_err),  32'd1);
    check_eq("run_ld_words",   32'(ld_words), 32'd4);

    // ld_done in RUN has no effect
    @(negedge clk);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    #1;
    check_eq("run_done_ignored", 32'(cpu_reset), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check_eq("run_done_ignored_late", 32'(cpu_reset), 32'd0);

    // reset with a read in flight
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h8; cpu_wbe = 4'h0;
    #1;
    check_eq("rstmid_cpu_gnt", 32'(cpu_gnt), 32'd1);
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    check_eq("rstmid_rvalid_dropped", 32'(cpu_rvalid), 32'd0);
    check_eq("rstmid_cpu_reset",      32'(cpu_reset),  32'd1);
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b1;
    #1;
    check_eq("rstmid_rvalid_after", 32'(cpu_rvalid), 32'd0);
    check_eq("rstmid_load_gnt",     32'(cpu_gnt),    32'd0);
    check_eq("rstmid_load_stall",   32'(cpu_stall),  32'd0);
    check_eq("rstmid_cpu_reset2",   32'(cpu_reset),  32'd1);
    check_eq("rstmid_ld_words",     32'(ld_words),   32'd0);
    check_eq("rstmid_oor_err",      32'(oor_err),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
